// File: rtl/simon_pkg.sv
// ---------------------------------------------------------------------------
// simon_pkg
// Shared definitions for the Simon-style game background sequencer:
//   - seq_state_t : playback FSM state encoding (IDLE / ON / OFF)
//   - BG_DARK     : background select value for "no pad lit"
//   - BG_LIT_BASE : background select value for pad 0; pad n is BG_LIT_BASE+n
//   - MAX_LEN     : default sequence memory depth in steps
//   - clamp_len() : limits a requested sequence length to the memory depth
// ---------------------------------------------------------------------------
package simon_pkg;

   localparam int MAX_LEN = 16;

   localparam logic [2:0] BG_DARK     = 3'd0;
   localparam logic [2:0] BG_LIT_BASE = 3'd1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } seq_state_t;

   // Requests longer than the memory would replay stale/unwritten steps,
   // so they are cut down to the memory depth.
   function automatic logic [4:0] clamp_len(input logic [4:0] req, input int unsigned cap);
      if (32'(req) > cap) begin
         return 5'(cap);
      end
      return req;
   endfunction

endpackage

// File: rtl/bg_sequencer_tick_timer.sv
// ---------------------------------------------------------------------------
// tick_timer
// Frame-tick down-counter. A load sets the count to load_val (the number of
// ticks still to wait minus one). Each frame tick decrements the count; the
// tick that arrives while the count is already zero is the expiry tick.
// A load on the same edge as a tick wins, so that tick is not counted.
//
// Ports
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset (count -> 0)
//   load      in   reload the counter this edge
//   load_val  in   value loaded (ticks-1)
//   tick      in   frame tick strobe
//   expire    out  combinational: tick present and count exhausted
// ---------------------------------------------------------------------------
module tick_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       tick,
   output logic       expire
);

   logic [7:0] count;

   assign expire = tick && (count == 8'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 8'd0;
      end else if (load) begin
         count <= load_val;
      end else if (tick && (count != 8'd0)) begin
         count <= count - 8'd1;
      end
   end

endmodule

// File: rtl/bg_sequencer.sv
// ---------------------------------------------------------------------------
// bg_sequencer
// Plays back a stored sequence of pad colours on the background select.
// Each step is lit for ON_TICKS frame ticks followed by OFF_TICKS dark ticks.
// The sequence memory is written only while idle; it keeps its contents
// through reset.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   frame_tick in   one-clk pulse per video frame (timing base)
//   wr_en      in   sequence memory write strobe (accepted only while idle)
//   wr_addr    in   step index written
//   wr_data    in   pad colour 0..3
//   seq_len    in   number of steps to play, sampled on start
//   start      in   one-clk playback request (ignored while busy or len 0)
//   abort      in   one-clk cancel request
//   bg         out  0 = dark, 1..4 = pad 0..3 lit (registered)
//   busy       out  playback in progress (registered)
//   done       out  one-clk pulse on normal completion (registered)
//   step_idx   out  step currently shown (registered)
// ---------------------------------------------------------------------------
module bg_sequencer
   import simon_pkg::*;
#(
   parameter int MAX_LEN   = simon_pkg::MAX_LEN,
   parameter int ON_TICKS  = 30,
   parameter int OFF_TICKS = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       wr_en,
   input  logic [3:0] wr_addr,
   input  logic [1:0] wr_data,
   input  logic [4:0] seq_len,
   input  logic       start,
   input  logic       abort,
   output logic [2:0] bg,
   output logic       busy,
   output logic       done,
   output logic [3:0] step_idx
);

   localparam logic [7:0] ON_LOAD  = 8'(ON_TICKS - 1);
   localparam logic [7:0] OFF_LOAD = 8'(OFF_TICKS - 1);

   logic [1:0]  mem [MAX_LEN];

   seq_state_t  state;
   seq_state_t  state_n;
   logic [4:0]  len;
   logic [4:0]  len_n;
   logic [3:0]  step_n;
   logic [2:0]  bg_n;
   logic        done_n;
   logic [1:0]  color_n;
   logic        wr_ok;

   logic        tmr_load;
   logic [7:0]  tmr_val;
   logic        tmr_expire;

   // Writes are dropped during playback so the sequence being shown
   // cannot change underneath it.
   assign wr_ok = wr_en && !busy && (32'(wr_addr) < MAX_LEN);

   // Sequence memory: deliberately outside the reset domain.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Colour of the step about to be shown. A write landing on the same edge
   // as start is forwarded so step 0 shows the new value immediately.
   always_comb begin
      color_n = mem[step_n];
      if (wr_ok && (wr_addr == step_n)) begin
         color_n = wr_data;
      end
   end

   // Next-state logic. abort is checked before timer expiry so a cancel
   // always wins over a coincident phase change or completion.
   always_comb begin
      state_n  = state;
      len_n    = len;
      step_n   = step_idx;
      done_n   = 1'b0;
      tmr_load = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (start && (seq_len != 5'd0)) begin
               state_n  = ST_ON;
               len_n    = clamp_len(seq_len, MAX_LEN);
               step_n   = 4'd0;
               tmr_load = 1'b1;
            end
         end

         ST_ON: begin
            if (abort) begin
               state_n  = ST_IDLE;
               step_n   = 4'd0;
               tmr_load = 1'b1;
            end else if (tmr_expire) begin
               state_n  = ST_OFF;
               tmr_load = 1'b1;
            end
         end

         ST_OFF: begin
            if (abort) begin
               state_n  = ST_IDLE;
               step_n   = 4'd0;
               tmr_load = 1'b1;
            end else if (tmr_expire) begin
               tmr_load = 1'b1;
               if ({1'b0, step_idx} == (len - 5'd1)) begin
                  state_n = ST_IDLE;
                  step_n  = 4'd0;
                  done_n  = 1'b1;
               end else begin
                  state_n = ST_ON;
                  step_n  = step_idx + 4'd1;
               end
            end
         end

         default: begin
            state_n  = ST_IDLE;
            step_n   = 4'd0;
            tmr_load = 1'b1;
         end
      endcase
   end

   // Output and timer reload values follow the state being entered, which
   // keeps bg/busy aligned with the state register.
   always_comb begin
      bg_n    = BG_DARK;
      tmr_val = 8'd0;
      case (state_n)
         ST_ON: begin
            bg_n    = BG_LIT_BASE + {1'b0, color_n};
            tmr_val = ON_LOAD;
         end
         ST_OFF: begin
            tmr_val = OFF_LOAD;
         end
         default: begin
            bg_n    = BG_DARK;
            tmr_val = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         len      <= 5'd0;
         step_idx <= 4'd0;
         bg       <= BG_DARK;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         len      <= len_n;
         step_idx <= step_n;
         bg       <= bg_n;
         busy     <= (state_n != ST_IDLE);
         done     <= done_n;
      end
   end

   tick_timer u_tick_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tick     (frame_tick),
      .expire   (tmr_expire)
   );

endmodule
